wall_scroller: RTL and testbench
================================

# wall_scroller

Multi-wall obstacle generator for the game datapath. It keeps `NUM_WALLS` walls scrolling left at a runtime-selectable speed, one step per frame tick. Each wall respawns off-screen on the right with a pseudo-random hole position, and the block counts walls that pass the bird. It sits between the frame-tick generator and the renderer/collision logic, and the collision detector can halt it.

## Interface
Parameters:
- `NUM_WALLS`, 2: number of independent walls.
- `X_W`, 8: width of each wall x coordinate.
- `Y_W`, 7: width of each hole-top y coordinate.
- `SCREEN_W`, 160: visible width; a wall is visible when x < `SCREEN_W`.
- `SCREEN_H`, 120: visible height.
- `WALL_WIDTH`, 8: wall thickness in pixels.
- `HOLE_H`, 50: hole height in pixels.
- `SPACING`, 80: x distance between consecutive walls.
- `SPEED_W`, 3: width of the `speed` input.
- `BIRD_X`, 40: x column that scores when a wall passes it.
- `HOLE_DEFAULT`, 35: hole_y value at reset and after start.
- `LFSR_SEED`, 8'hA5: LFSR value at reset; must be nonzero.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new game; honoured in IDLE and OVER only.
- `pause` in 1: level input; high freezes motion.
- `halt` in 1: collision indication; ends the game.
- `tick` in 1: one-cycle frame strobe.
- `speed` in `SPEED_W`: pixels moved per tick; 0 is legal and means no motion.
- `wall_x` out `NUM_WALLS*X_W`: packed x positions, wall i at bits [i*X_W +: X_W].
- `hole_y` out `NUM_WALLS*Y_W`: packed hole-top y positions.
- `visible` out `NUM_WALLS`: bit i is 1 when wall_x[i] < `SCREEN_W`.
- `score` out 8: saturating count of walls passed.
- `score_pulse` out 1: one-cycle strobe on each scoring update.
- `state` out 2: current FSM state.

Elaboration-time checks:
- `SCREEN_W + (NUM_WALLS-1)*SPACING < 2^X_W`.
- `NUM_WALLS*SPACING >= SCREEN_W`.
- `BIRD_X >= WALL_WIDTH + 2^SPEED_W`.
- `SCREEN_H - HOLE_H <= 2^Y_W - 1`.

## Operation
- FSM states: IDLE=0, RUN=1, PAUSED=2, OVER=3.
  - IDLE→RUN on `start`.
  - RUN→OVER on `halt`; otherwise RUN→PAUSED on `pause`.
  - PAUSED→OVER on `halt`; otherwise PAUSED→RUN when `!pause`.
  - OVER→RUN on `start`.
  - Priority order: `halt` > `pause` > `tick`.
- On any `start` that is honoured:
  - wall_x[i] = `SCREEN_W + i*SPACING`.
  - hole_y[i] = `HOLE_DEFAULT`.
  - score = 0.
- Move: happens only in RUN, on `tick`, with no `halt` and no `pause`. All walls update in parallel, for each i:
  - If x < speed, respawn: x ← x + `NUM_WALLS*SPACING` − speed, computed in X_W+1 bits, and hole_y[i] ← new hole value. This keeps spacing exact.
  - Otherwise: x ← x − speed. No underflow is possible.
- New hole value: r = lfsr[6:0]; hole = (r >= M) ? r − M : r, where M = `SCREEN_H − HOLE_H` (70 with defaults). Walls that respawn on the same tick take hole values from consecutive LFSR bits: wall i uses lfsr rotated by i.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Advances every clock in every state except reset, so the hole sequence depends on tick timing.
- Scoring: a wall scores when it moves without respawning and old x + `WALL_WIDTH` >= `BIRD_X` while new x + `WALL_WIDTH` < `BIRD_X`.
  - score increases by the number of walls scoring on that tick, saturating at 255.
  - `score_pulse` goes high if at least one wall scored.
- `tick` is ignored in IDLE, PAUSED and OVER, and on the edge where `start` is honoured.

## Timing
- Reset values:
  - state = IDLE.
  - wall_x[i] = `SCREEN_W + i*SPACING`.
  - hole_y[i] = `HOLE_DEFAULT`.
  - visible = 0.
  - score = 0, score_pulse = 0.
  - lfsr = `LFSR_SEED`.
- Reset mid-game forces these values immediately, without waiting for a clock edge.
- Latency is 1 cycle: all outputs are registered and reflect a move from the clock edge after the tick cycle.
- `score_pulse` is high for exactly one cycle, aligned with the updated `score`.
- `visible` is registered and derived from the next-state x, so it is coherent with `wall_x`.
- A `speed` change takes effect on the next tick. No other synchronisation is required.

## Structure
- Package `wall_pkg` holds:
  - the FSM state encodings;
  - the LFSR tap mask;
  - the default geometry constants.
- Sub-module `wall_lfsr` is an 8-bit LFSR with ports clk, reset, q[7:0] and parameter SEED.
- The per-wall update is a generate loop over `NUM_WALLS`.

## Test plan
All scenarios use default parameters.
- Start + tick, speed=4: wall_x = {160,240} → {156,236}; visible = 2'b01; no score.
- Respawn: wall0 at x=2, speed=4, tick → wall0 x=158 and hole_y[0] = LFSR-derived value in [0,69]; wall1 moves by exactly 4.
- Score: wall0 at x=34, speed=4, tick → x=30, score 0→1, score_pulse high for exactly 1 cycle; a further tick gives no pulse.
- Pause and halt:
  - pause high during 5 ticks → positions unchanged; pause low then tick → motion resumes.
  - halt and tick in the same cycle → state=OVER, positions unchanged.
- Reset and start sequencing:
  - Reset asserted mid-RUN between edges → outputs return to reset values immediately.
  - Start from OVER with score=255 reloads positions and clears score.
  - Score saturation: preload score=255 and force a scoring tick → score stays 255.

Source files
------------

// File: rtl/wall_pkg.sv
// Shared state encodings, LFSR taps and default geometry for the wall scroller.
package wall_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } wall_state_t;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 with a left shift: bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int         DEF_NUM_WALLS    = 2;
    localparam int         DEF_X_W          = 8;
    localparam int         DEF_Y_W          = 7;
    localparam int         DEF_SCREEN_W     = 160;
    localparam int         DEF_SCREEN_H     = 120;
    localparam int         DEF_WALL_WIDTH   = 8;
    localparam int         DEF_HOLE_H       = 50;
    localparam int         DEF_SPACING      = 80;
    localparam int         DEF_SPEED_W      = 3;
    localparam int         DEF_BIRD_X       = 40;
    localparam int         DEF_HOLE_DEFAULT = 35;
    localparam logic [7:0] DEF_LFSR_SEED    = 8'hA5;

endpackage

// File: rtl/wall_lfsr.sv
// Free-running 8-bit Fibonacci LFSR feeding the hole position generator.
module wall_lfsr
    import wall_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= SEED;
        else       q <= {q[6:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/wall_scroller.sv
// Scrolls NUM_WALLS walls left one step per frame tick, respawning them on the
// right with pseudo-random holes and counting walls that pass the bird column.
module wall_scroller
    import wall_pkg::*;
#(
    parameter int         NUM_WALLS    = DEF_NUM_WALLS,
    parameter int         X_W          = DEF_X_W,
    parameter int         Y_W          = DEF_Y_W,
    parameter int         SCREEN_W     = DEF_SCREEN_W,
    parameter int         SCREEN_H     = DEF_SCREEN_H,
    parameter int         WALL_WIDTH   = DEF_WALL_WIDTH,
    parameter int         HOLE_H       = DEF_HOLE_H,
    parameter int         SPACING      = DEF_SPACING,
    parameter int         SPEED_W      = DEF_SPEED_W,
    parameter int         BIRD_X       = DEF_BIRD_X,
    parameter int         HOLE_DEFAULT = DEF_HOLE_DEFAULT,
    parameter logic [7:0] LFSR_SEED    = DEF_LFSR_SEED
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     halt,
    input  logic                     tick,
    input  logic [SPEED_W-1:0]       speed,
    output logic [NUM_WALLS*X_W-1:0] wall_x,
    output logic [NUM_WALLS*Y_W-1:0] hole_y,
    output logic [NUM_WALLS-1:0]     visible,
    output logic [7:0]               score,
    output logic                     score_pulse,
    output logic [1:0]               state
);

    localparam int             CNT_W      = $clog2(NUM_WALLS + 1);
    localparam logic [X_W:0]   LOOP_W     = (X_W+1)'(NUM_WALLS * SPACING);
    localparam logic [X_W:0]   BIRD_W     = (X_W+1)'(BIRD_X);
    localparam logic [X_W:0]   THICK_W    = (X_W+1)'(WALL_WIDTH);
    localparam logic [X_W-1:0] SCREEN_XW  = X_W'(SCREEN_W);
    localparam logic [6:0]     HOLE_M     = 7'(SCREEN_H - HOLE_H);
    localparam logic [Y_W-1:0] HOLE_DEF_Y = Y_W'(HOLE_DEFAULT);

    if (SCREEN_W + (NUM_WALLS-1)*SPACING >= 2**X_W) begin : g_chk_xrange
        $error("wall_scroller: furthest wall start does not fit in X_W bits");
    end
    if (NUM_WALLS*SPACING < SCREEN_W) begin : g_chk_spacing
        $error("wall_scroller: walls do not cover the screen width");
    end
    if (BIRD_X < WALL_WIDTH + 2**SPEED_W) begin : g_chk_bird
        $error("wall_scroller: BIRD_X too close to the left edge for max speed");
    end
    if (SCREEN_H - HOLE_H > 2**Y_W - 1) begin : g_chk_hole
        $error("wall_scroller: hole range does not fit in Y_W bits");
    end
    if (LFSR_SEED == 8'h00) begin : g_chk_seed
        $error("wall_scroller: LFSR_SEED must be nonzero");
    end

    wall_state_t                        state_q, state_d;
    logic [NUM_WALLS-1:0][X_W-1:0]      x_q, x_d, x_mv, x_init;
    logic [NUM_WALLS-1:0][Y_W-1:0]      hole_q, hole_d, hole_mv;
    logic [NUM_WALLS-1:0]               vis_q, vis_d, scored;
    logic [7:0]                         score_q, score_d;
    logic                               pulse_q, pulse_d;
    logic [CNT_W-1:0]                   n_scored;
    logic [15:0]                        score_sum;
    logic [7:0]                         lfsr;
    logic                               start_ok, move;

    wall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_OVER);
    assign move     = (state_q == ST_RUN) && tick && !halt && !pause;

    for (genvar i = 0; i < NUM_WALLS; i++) begin : g_wall
        logic [6:0]     r;
        logic [X_W:0]   xw, xs, old_e, new_e;
        logic [X_W-1:0] x_wrap;
        logic           resp;

        assign x_init[i] = X_W'(SCREEN_W + i*SPACING);

        // Wall i draws its hole from the LFSR rotated right by i, so walls
        // respawning together still get different holes.
        always_comb begin
            r = '0;
            for (int b = 0; b < 7; b++) r[b] = lfsr[(b + i) % 8];
        end

        assign xw     = {1'b0, x_q[i]};
        assign xs     = (X_W+1)'(speed);
        assign resp   = xw < xs;
        assign x_wrap = X_W'(xw + LOOP_W - xs);
        assign x_mv[i] = resp ? x_wrap : x_q[i] - xs[X_W-1:0];
        assign hole_mv[i] = resp ? Y_W'((r >= HOLE_M) ? r - HOLE_M : r) : hole_q[i];

        assign old_e     = xw + THICK_W;
        assign new_e     = {1'b0, x_mv[i]} + THICK_W;
        assign scored[i] = !resp && (old_e >= BIRD_W) && (new_e < BIRD_W);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RUN;
            ST_RUN:    if (halt) state_d = ST_OVER;
                       else if (pause) state_d = ST_PAUSED;
            ST_PAUSED: if (halt) state_d = ST_OVER;
                       else if (!pause) state_d = ST_RUN;
            ST_OVER:   if (start) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_d       = x_q;
        hole_d    = hole_q;
        score_d   = score_q;
        pulse_d   = 1'b0;
        n_scored  = '0;
        score_sum = '0;
        for (int i = 0; i < NUM_WALLS; i++) n_scored = n_scored + CNT_W'(scored[i]);
        if (start_ok) begin
            x_d     = x_init;
            hole_d  = {NUM_WALLS{HOLE_DEF_Y}};
            score_d = '0;
        end else if (move) begin
            x_d       = x_mv;
            hole_d    = hole_mv;
            score_sum = 16'(score_q) + 16'(n_scored);
            score_d   = (score_sum > 16'd255) ? 8'hFF : score_sum[7:0];
            pulse_d   = |scored;
        end
        // Visibility is taken from the next-state x so it lines up with wall_x.
        for (int i = 0; i < NUM_WALLS; i++) vis_d[i] = x_d[i] < SCREEN_XW;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= x_init;
            hole_q  <= {NUM_WALLS{HOLE_DEF_Y}};
            vis_q   <= '0;
            score_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            hole_q  <= hole_d;
            vis_q   <= vis_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
        end
    end

    assign wall_x      = x_q;
    assign hole_y      = hole_q;
    assign visible     = vis_q;
    assign score       = score_q;
    assign score_pulse = pulse_q;
    assign state       = state_q;

endmodule

// File: tb/tb_wall_scroller.sv
// Directed bench for wall_scroller: a behavioural game model pushes the expected
// outputs for each cycle into a scoreboard that is popped after the clock edge.
module tb_wall_scroller;

    localparam int NW = 2;
    localparam int XW = 8;
    localparam int YW = 7;

    logic             clk = 1'b0;
    logic             reset, start, pause, halt, tick;
    logic [2:0]       speed;
    logic [NW*XW-1:0] wall_x;
    logic [NW*YW-1:0] hole_y;
    logic [NW-1:0]    visible;
    logic [7:0]       score;
    logic             score_pulse;
    logic [1:0]       state;

    wall_scroller dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .halt        (halt),
        .tick        (tick),
        .speed       (speed),
        .wall_x      (wall_x),
        .hole_y      (hole_y),
        .visible     (visible),
        .score       (score),
        .score_pulse (score_pulse),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW*XW-1:0] wx;
        logic [NW*YW-1:0] hy;
        logic [NW-1:0]    vis;
        logic [7:0]       sc;
        logic             pl;
        logic [1:0]       st;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         m_x[NW];
    int         m_hole[NW];
    int         m_score;
    bit         m_pulse;
    int         m_state;
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_x[i]    = 160 + i*80;
            m_hole[i] = 35;
        end
        m_score = 0;
        m_pulse = 0;
        m_state = 0;
        m_lfsr  = 8'hA5;
    endtask

    task automatic model_step(input bit st, input bit pa, input bit ha, input bit tk, input int sp);
        bit ok, mv;
        int ns, cnt, nx, r;
        ok = st && (m_state == 0 || m_state == 3);
        mv = (m_state == 1) && tk && !ha && !pa;
        ns = m_state;
        case (m_state)
            0: if (st) ns = 1;
            1: if (ha) ns = 3; else if (pa) ns = 2;
            2: if (ha) ns = 3; else if (!pa) ns = 1;
            default: if (st) ns = 1;
        endcase
        cnt     = 0;
        m_pulse = 0;
        if (ok) begin
            for (int i = 0; i < NW; i++) begin
                m_x[i]    = 160 + i*80;
                m_hole[i] = 35;
            end
            m_score = 0;
        end else if (mv) begin
            for (int i = 0; i < NW; i++) begin
                if (m_x[i] < sp) begin
                    m_x[i] = m_x[i] + 160 - sp;
                    r = 0;
                    for (int b = 0; b < 7; b++) if (m_lfsr[(b + i) % 8]) r += (1 << b);
                    m_hole[i] = (r >= 70) ? r - 70 : r;
                end else begin
                    nx = m_x[i] - sp;
                    if (m_x[i] + 8 >= 40 && nx + 8 < 40) cnt++;
                    m_x[i] = nx;
                end
            end
            m_score = (m_score + cnt > 255) ? 255 : m_score + cnt;
            m_pulse = (cnt > 0);
        end
        m_state = ns;
        m_lfsr  = lfsr_next(m_lfsr);
    endtask

    function automatic exp_t snap();
        exp_t e;
        for (int i = 0; i < NW; i++) begin
            e.wx[i*XW +: XW] = XW'(m_x[i]);
            e.hy[i*YW +: YW] = YW'(m_hole[i]);
            e.vis[i]         = (m_x[i] < 160);
        end
        e.sc = 8'(m_score);
        e.pl = m_pulse;
        e.st = 2'(m_state);
        return e;
    endfunction

    task automatic check_sb(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty got=%0d exp=1", tag, sb.size());
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        checks++;
        assert (wall_x === e.wx) else begin
            errors++; $error("FAIL %s wall_x got=%h exp=%h", tag, wall_x, e.wx);
        end
        checks++;
        assert (hole_y === e.hy) else begin
            errors++; $error("FAIL %s hole_y got=%h exp=%h", tag, hole_y, e.hy);
        end
        checks++;
        assert (visible === e.vis) else begin
            errors++; $error("FAIL %s visible got=%b exp=%b", tag, visible, e.vis);
        end
        checks++;
        assert (score === e.sc) else begin
            errors++; $error("FAIL %s score got=%0d exp=%0d", tag, score, e.sc);
        end
        checks++;
        assert (score_pulse === e.pl) else begin
            errors++; $error("FAIL %s score_pulse got=%b exp=%b", tag, score_pulse, e.pl);
        end
        checks++;
        assert (state === e.st) else begin
            errors++; $error("FAIL %s state got=%0d exp=%0d", tag, state, e.st);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge and sampled 1 unit after the next.
    task automatic step(input string tag, input bit st, input bit pa, input bit ha,
                        input bit tk, input int sp);
        start = st; pause = pa; halt = ha; tick = tk; speed = 3'(sp);
        model_step(st, pa, ha, tk, sp);
        sb.push_back(snap());
        @(posedge clk);
        #1;
        check_sb(tag);
    endtask

    initial begin
        logic [15:0] saved_x;
        int          sc0, guard;

        reset = 1'b1; start = 1'b0; pause = 1'b0; halt = 1'b0; tick = 1'b0; speed = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(snap());
        check_sb("reset");
        chk("reset_state", 32'(state), 32'd0);
        reset = 1'b0;

        // Start with a tick on the same edge: tick is ignored, walls stay loaded.
        step("start", 1, 0, 0, 1, 4);
        step("first_move", 0, 0, 0, 1, 4);
        chk("first_move_x", 32'(wall_x), 32'({8'd236, 8'd156}));
        chk("first_move_vis", 32'(visible), 32'd1);
        step("speed0", 0, 0, 0, 1, 0);
        chk("speed0_x", 32'(wall_x), 32'({8'd236, 8'd156}));

        // Bring wall0 to x=2, then respawn it.
        repeat (22) step("approach", 0, 0, 0, 1, 7);
        chk("pre_respawn_x0", 32'(wall_x[7:0]), 32'd2);
        step("respawn", 0, 0, 0, 1, 4);
        chk("respawn_x0", 32'(wall_x[7:0]), 32'd158);
        chk("respawn_x1", 32'(wall_x[15:8]), 32'd78);
        chk("respawn_hole_range", 32'(hole_y[6:0] < 7'd70), 32'd1);

        // Bring wall0 to x=34 so the next 4-pixel step crosses the bird.
        repeat (31) step("to_bird", 0, 0, 0, 1, 4);
        chk("at_bird_x0", 32'(wall_x[7:0]), 32'd34);
        sc0 = m_score;
        step("score", 0, 0, 0, 1, 4);
        chk("score_x0", 32'(wall_x[7:0]), 32'd30);
        chk("score_inc", 32'(score), 32'(sc0 + 1));
        chk("score_pulse_hi", 32'(score_pulse), 32'd1);
        step("post_score", 0, 0, 0, 1, 4);
        chk("score_pulse_lo", 32'(score_pulse), 32'd0);

        // Pause freezes motion through ticks; release takes one cycle to resume.
        saved_x = wall_x;
        repeat (5) step("paused", 0, 1, 0, 1, 4);
        chk("pause_hold", 32'(wall_x), 32'(saved_x));
        chk("pause_state", 32'(state), 32'd2);
        step("unpause", 0, 0, 0, 1, 4);
        step("resume", 0, 0, 0, 1, 4);

        // Halt beats tick.
        saved_x = wall_x;
        step("halt", 0, 0, 1, 1, 4);
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_hold", 32'(wall_x), 32'(saved_x));
        step("over_tick", 0, 0, 0, 1, 4);
        step("restart", 1, 0, 0, 1, 4);

        // Run long enough to saturate the score, then keep scoring past 255.
        guard = 0;
        while (m_score < 255 && guard < 5000) begin
            step("to_sat", 0, 0, 0, 1, 7);
            guard++;
        end
        chk("sat_reached", 32'(score), 32'd255);
        repeat (60) step("saturated", 0, 0, 0, 1, 7);
        chk("sat_hold", 32'(score), 32'd255);

        step("halt2", 0, 0, 1, 0, 7);
        step("restart2", 1, 0, 0, 0, 7);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_x", 32'(wall_x), 32'({8'd240, 8'd160}));
        step("run_a", 0, 0, 0, 1, 5);
        step("run_b", 0, 0, 0, 1, 3);
        step("run_c", 0, 0, 0, 1, 6);

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        model_reset();
        sb.push_back(snap());
        check_sb("async_reset");
        #1 reset = 1'b0;
        step("idle_after_reset", 0, 0, 0, 1, 4);
        step("start_after_reset", 1, 0, 0, 0, 4);
        step("move_after_reset", 0, 0, 0, 1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
